// File: rtl/mult_datapath.sv
// Datapath for the 8-bit signed shift-add multiplier: X/A/B shift chain, 9-bit add/sub unit, 3-bit shift counter.
// Optional MULT_PRODUCT_LATCH_EN adds a registered product and a one-cycle done pulse.
module mult_datapath (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  SW,
    input  logic        ClearAX_LoadB,
    input  logic        Ld_A,
    input  logic        Sub,
    input  logic        shift_en,
    input  logic        Ld_x,
    output logic        M,
    output logic [2:0]  count,
    output logic        X,
    output logic [7:0]  Aval,
    output logic [7:0]  Bval,
    output logic [15:0] product,
    output logic        done
);

    logic       r_x;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [2:0] r_count;

    logic [8:0] w_s_ext;
    logic [8:0] w_a_ext;
    logic [8:0] w_operand;
    logic [8:0] w_sum;

    // Subtract is invert-plus-one; carry out of bit 8 is dropped by the 9-bit result.
    assign w_s_ext   = {SW[7], SW};
    assign w_a_ext   = {r_a[7], r_a};
    assign w_operand = Sub ? ~w_s_ext : w_s_ext;
    assign w_sum     = w_a_ext + w_operand + {8'd0, Sub};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_x     <= 1'b0;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_count <= 3'd0;
        end else if (ClearAX_LoadB) begin
            r_x     <= 1'b0;
            r_a     <= 8'h00;
            r_b     <= SW;
            r_count <= 3'd0;
        end else if (Sub || Ld_A) begin
            r_x <= w_sum[8];
            r_a <= w_sum[7:0];
        end else if (shift_en) begin
            r_a     <= {r_x, r_a[7:1]};
            r_b     <= {r_a[0], r_b[7:1]};
            r_count <= r_count + 3'd1;
        end else if (Ld_x) begin
            r_x <= r_a[7];
        end
    end

    assign M     = r_b[0];
    assign count = r_count;
    assign X     = r_x;
    assign Aval  = r_a;
    assign Bval  = r_b;

`ifdef MULT_PRODUCT_LATCH_EN
    logic        w_shift_fire;
    logic [15:0] r_product;
    logic        r_done;

    // A shift only happens when no higher-priority strobe claims the edge.
    assign w_shift_fire = shift_en && !ClearAX_LoadB && !Sub && !Ld_A;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_product <= 16'h0000;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_shift_fire && (r_count == 3'd7)) begin
                r_product <= {r_x, r_a, r_b[7:1]};
                r_done    <= 1'b1;
            end
        end
    end

    assign product = r_product;
    assign done    = r_done;
`else
    assign product = {r_a, r_b};
    assign done    = 1'b0;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Directed testbench for mult_datapath: reset, load, add/sub corners, full multiplies, priority and reset abort.
module tb_mult_datapath;

    logic        Clk;
    logic        Reset;
    logic [7:0]  SW;
    logic        ClearAX_LoadB;
    logic        Ld_A;
    logic        Sub;
    logic        shift_en;
    logic        Ld_x;
    logic        M;
    logic [2:0]  count;
    logic        X;
    logic [7:0]  Aval;
    logic [7:0]  Bval;
    logic [15:0] product;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;

    mult_datapath dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .SW            (SW),
        .ClearAX_LoadB (ClearAX_LoadB),
        .Ld_A          (Ld_A),
        .Sub           (Sub),
        .shift_en      (shift_en),
        .Ld_x          (Ld_x),
        .M             (M),
        .count         (count),
        .X             (X),
        .Aval          (Aval),
        .Bval          (Bval),
        .product       (product),
        .done          (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Reset = 0; ClearAX_LoadB = 0; Ld_A = 0; Sub = 0; shift_en = 0; Ld_x = 0;
    endtask

    // One clock edge; outputs sampled 1 time unit later.
    task automatic step();
        @(posedge Clk);
        #1;
        idle();
    endtask

    task automatic chk_state(input string tag, input logic x, input logic [7:0] a,
                             input logic [7:0] b, input logic [2:0] c);
        chk({tag, ".X"}, {15'd0, X}, {15'd0, x});
        chk({tag, ".A"}, {8'd0, Aval}, {8'd0, a});
        chk({tag, ".B"}, {8'd0, Bval}, {8'd0, b});
        chk({tag, ".count"}, {13'd0, count}, {13'd0, c});
    endtask

    // Full signed multiply a(multiplicand on SW) * b(multiplier in B), strobes as the control FSM would issue.
    task automatic do_mult(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp_prod);
        SW = b; ClearAX_LoadB = 1; step();
        SW = a;
        for (int i = 0; i < 7; i++) begin
            chk({tag, ".M"}, {15'd0, M}, {15'd0, b[i]});
            if (b[i]) begin Ld_A = 1; step(); end
            shift_en = 1; step();
        end
        chk({tag, ".M7"}, {15'd0, M}, {15'd0, b[7]});
        chk({tag, ".cnt7"}, {13'd0, count}, 16'd7);
        if (b[7]) begin Sub = 1; step(); end
        shift_en = 1; step();
        chk({tag, ".AB"}, {Aval, Bval}, exp_prod);
        chk({tag, ".cnt0"}, {13'd0, count}, 16'd0);
        chk({tag, ".product"}, product, exp_prod);
`ifdef MULT_PRODUCT_LATCH_EN
        chk({tag, ".done"}, {15'd0, done}, 16'd1);
        step();
        chk({tag, ".done_drop"}, {15'd0, done}, 16'd0);
        chk({tag, ".prod_hold"}, product, exp_prod);
`else
        chk({tag, ".done"}, {15'd0, done}, 16'd0);
`endif
        $display("mult %s: %h * %h -> %h", tag, a, b, {Aval, Bval});
    endtask

    initial begin
        SW = 8'h00;
        idle();

        // Reset with every strobe high
        Reset = 1; ClearAX_LoadB = 1; Ld_A = 1; Sub = 1; shift_en = 1; Ld_x = 1; SW = 8'hFF;
        step();
        chk_state("reset", 1'b0, 8'h00, 8'h00, 3'd0);
        chk("reset.M", {15'd0, M}, 16'd0);
        chk("reset.product", product, 16'h0000);
        chk("reset.done", {15'd0, done}, 16'd0);
        $display("reset: X=%b A=%h B=%h count=%0d", X, Aval, Bval, count);

        // Load
        SW = 8'h05; ClearAX_LoadB = 1; step();
        chk_state("load", 1'b0, 8'h00, 8'h05, 3'd0);
        chk("load.M", {15'd0, M}, 16'd1);
        $display("load: B=%h M=%b", Bval, M);

        do_mult("5x-3", 8'hFD, 8'h05, 16'hFFF1);

        // Add overflow, then shift
        SW = 8'h00; ClearAX_LoadB = 1; step();
        SW = 8'h7F; Ld_A = 1; step();
        chk_state("add7F", 1'b0, 8'h7F, 8'h00, 3'd0);
        SW = 8'h01; Ld_A = 1; step();
        chk_state("addovf", 1'b0, 8'h80, 8'h00, 3'd0);
        // Idle cycle holds everything
        step();
        chk_state("hold", 1'b0, 8'h80, 8'h00, 3'd0);
        // Ld_A with Ld_x: X from sum[8] (80+80 -> 1_00), not from A[7]
        SW = 8'h80; Ld_A = 1; Ld_x = 1; step();
        chk_state("ldA_ldx", 1'b1, 8'h00, 8'h00, 3'd0);
        $display("ldA+ldx: X=%b A=%h", X, Aval);

        SW = 8'h00; ClearAX_LoadB = 1; step();
        SW = 8'h7F; Ld_A = 1; step();
        SW = 8'h01; Ld_A = 1; step();
        shift_en = 1; step();
        chk_state("ovfshift", 1'b0, 8'h40, 8'h00, 3'd1);
        $display("overflow shift: X=%b A=%h count=%0d", X, Aval, count);

        // Ld_x alone resyncs X from A[7]
        SW = 8'h00; ClearAX_LoadB = 1; step();
        SW = 8'h7F; Ld_A = 1; step();
        SW = 8'h01; Ld_A = 1; step();
        Ld_x = 1; step();
        chk_state("ldx", 1'b1, 8'h80, 8'h00, 3'd0);

        // Subtract from zero, then shift
        SW = 8'h00; ClearAX_LoadB = 1; step();
        SW = 8'h03; Sub = 1; step();
        chk_state("sub0", 1'b1, 8'hFD, 8'h00, 3'd0);
        shift_en = 1; step();
        chk_state("subshift", 1'b1, 8'hFE, 8'h80, 3'd1);
        $display("sub from zero: X=%b A=%h B=%h count=%0d", X, Aval, Bval, count);

        // Sub + shift_en: subtract only
        SW = 8'h00; ClearAX_LoadB = 1; step();
        SW = 8'h03; Sub = 1; shift_en = 1; step();
        chk_state("sub_prio", 1'b1, 8'hFD, 8'h00, 3'd0);
        $display("sub+shift: A=%h count=%0d", Aval, count);

        do_mult("80x80", 8'h80, 8'h80, 16'h4000);
        do_mult("FFxFF", 8'hFF, 8'hFF, 16'h0001);

        // Reset mid-multiply
        SW = 8'h05; ClearAX_LoadB = 1; step();
        SW = 8'hFD;
        Ld_A = 1; step();
        shift_en = 1; step();
        shift_en = 1; step();
        shift_en = 1; step();
        chk("midrst.cnt3", {13'd0, count}, 16'd3);
        Reset = 1; Ld_A = 1; shift_en = 1; step();
        chk_state("midrst", 1'b0, 8'h00, 8'h00, 3'd0);
        chk("midrst.product", product, 16'h0000);
        $display("reset mid-op: X=%b A=%h B=%h count=%0d", X, Aval, Bval, count);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_datapath.md
# mult_datapath

Register and arithmetic datapath for the 8-bit signed shift-add multiplier. It holds the X/A/B shift chain, the 9-bit add/subtract unit and the 3-bit shift counter. It executes the strobes issued by the multiplier control FSM each cycle and returns `M` and `count` to that FSM. The final product is available as `{X,A,B}`'s low 16 bits (`{Aval,Bval}`).

## Interface

Parameters:
- none; width is fixed at 8 bits per operand.

Ports:
- `Clk` in 1 — the single clock; all state updates on its rising edge.
- `Reset` in 1 — synchronous, active-high; clears all state.
- `SW` in 8 — switch operand:
  - loaded into B on `ClearAX_LoadB`;
  - used live as multiplicand S during `Ld_A`/`Sub`;
  - must be held stable for the whole multiply.
- `ClearAX_LoadB` in 1 — A, X and count go to 0; B is loaded from `SW`.
- `Ld_A` in 1 — A and X are loaded from the 9-bit sum `{A[7],A} + {S[7],S}`.
- `Sub` in 1 — A and X are loaded from `{A[7],A} - {S[7],S}`, computed as invert plus carry-in 1.
- `shift_en` in 1 — arithmetic right shift of `{X,A,B}`; count increments.
- `Ld_x` in 1 — X is loaded from A[7] (sign resync); A, B and count hold.
- `M` out 1 — equals B[0]; combinational from the register.
- `count` out 3 — number of shifts completed, modulo 8.
- `X` out 1, `Aval` out 8, `Bval` out 8 — register contents.
- `product` out 16, `done` out 1 — see Configuration.

## Operation

- At most one action is applied per clock edge. Priority, highest first:
  1. `Reset`
  2. `ClearAX_LoadB`
  3. `Sub`
  4. `Ld_A`
  5. `shift_en`
  6. `Ld_x`
- With no strobe asserted, all registers hold.
- Adder:
  - Operands are sign-extended to 9 bits. The result is kept to 9 bits and the carry out of bit 8 is discarded.
  - `X <= sum[8]`, `A <= sum[7:0]`. B and count are unchanged.
- Shift:
  - `X <= X` (sign preserved).
  - `A <= {X, A[7:1]}`.
  - `B <= {A[0], B[7:1]}`.
  - `count <= count + 1`, wrapping from 7 to 0.
- Count wrap:
  - After the 8th shift, count returns to 0 with no extra action.
  - A new multiply without `ClearAX_LoadB` accumulates into the existing A.
- There is no internal FSM. Sequencing belongs to the control block. This block is a strobe-driven register file with a counter.

## Timing

- Reset values: X=0, A=8'h00, B=8'h00, count=0, M=0, product=16'h0000, done=0.
- `Reset` takes effect at the same edge where it is sampled and overrides every strobe.
  - Reset mid-multiply aborts the operation; the next cycle shows all zeros.
- Every strobe has a 1-cycle latency: registers reflect the action in the cycle after the edge.
- `M` and `count` are registered outputs. The control FSM sees the post-shift B[0] and count one cycle after the `shift_en` edge.
- Simultaneous strobes resolve by the priority list in Operation. Examples:
  - `Sub` together with `shift_en`: only the subtract occurs, and count does not advance.
  - `Ld_A` together with `Ld_x`: `Ld_A` wins, so X comes from sum[8].
- Combinational path SW→adder→A/X: one cycle, no pipelining.

## Configuration

- `MULT_PRODUCT_LATCH_EN` defined:
  - Adds a 16-bit `product` register and a `done` pulse.
  - On the `shift_en` edge where count goes 7→0, `product` captures the post-shift `{A,B}`.
  - `done` is high for exactly the following cycle.
  - Both clear on `Reset`. `product` holds across `ClearAX_LoadB`.
- `MULT_PRODUCT_LATCH_EN` not defined:
  - `product` is driven combinationally as `{Aval,Bval}`.
  - `done` is tied to 0.
  - No extra flops.

## Test plan

- **Reset:** assert `Reset` for 1 cycle with all strobes high -> X=0, A=00, B=00, count=0, M=0.
- **Load:** `ClearAX_LoadB` with SW=8'h05 -> B=05, A=00, X=0, M=1. Then set SW=8'hFD and drive the sequence: `Ld_A` on cycles where M=1; `shift_en` ×7; then `Sub` if M=1, else none; then a final `shift_en` -> `{A,B}` = 16'hFFF1 (5×−3 = −15), count=0.
- **Add overflow:** A=7F via a prior add, S=8'h01, `Ld_A` -> A=8'h80, X=0. Then `shift_en` -> A=8'h40, X=0.
- **Subtract from zero:** A=00, S=8'h03, `Sub` -> A=8'hFD, X=1. Then `shift_en` -> A=8'hFE, X=1, count +1.
- **Corner product:** B=8'h80, S=8'h80, full multiply -> `{A,B}` = 16'h4000. Repeat with B=FF, S=FF -> 16'h0001.
- **Reset mid-operation and priority:**
  - `Reset` after 3 shifts -> all zero next cycle.
  - `Sub`+`shift_en` in the same cycle -> subtract only, count unchanged.
  - With `MULT_PRODUCT_LATCH_EN` defined: `done` is high 1 cycle after the 8th shift and `product` equals the final `{A,B}`.
